// File: rtl/toast_pkg.sv
// Shared types and helpers for the Toast unified-memory arbiter.
// Holds the response-owner encoding and the legal data byte-enable rule.
package toast_pkg;

  localparam int unsigned ADDR_W_DEF = 32;

  typedef enum logic [2:0] {
    R_NONE = 3'd0,
    R_IMEM = 3'd1,
    R_DMEM = 3'd2,
    R_IERR = 3'd3,
    R_DERR = 3'd4
  } resp_owner_t;

  // Byte, halfword and word lane patterns; zero means a word read.
  function automatic logic be_legal(input logic [3:0] be);
    logic ok;
    case (be)
      4'b0000, 4'b0001, 4'b0010, 4'b0100,
      4'b1000, 4'b0011, 4'b1100, 4'b1111: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/toast_arb_starve_ctr.sv
// Saturating counter with synchronous clear, increment and terminal-count flag.
// Tracks consecutive data grants taken while a fetch is left waiting.
module toast_arb_starve_ctr #(
  parameter int unsigned MAX = 4,
  parameter int unsigned CW  = 3
) (
  input  logic          clk_i,
  input  logic          resetn_i,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          tc_s;

  assign tc_s  = (cnt_q == CW'(MAX));
  assign tc_o  = tc_s;
  assign cnt_o = cnt_q;

  // Clear dominates; increment holds once the terminal count is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !tc_s) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter state register.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/toast_mem_arbiter.sv
// Merges the Toast fetch and data ports onto one single-port synchronous RAM.
// Data wins ties unless a fetch has been passed over MAX_D_BURST times in a row.
module toast_mem_arbiter
  import toast_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned MAX_D_BURST = 4
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              imem_req_i,
  input  logic [ADDR_W-1:0] imem_addr_i,
  output logic              imem_gnt_o,
  output logic              imem_rvalid_o,
  output logic [31:0]       imem_rdata_o,
  output logic              imem_err_o,
  input  logic              dmem_req_i,
  input  logic [ADDR_W-1:0] dmem_addr_i,
  input  logic [3:0]        dmem_be_i,
  input  logic [31:0]       dmem_wdata_i,
  output logic              dmem_gnt_o,
  output logic              dmem_rvalid_o,
  output logic [31:0]       dmem_rdata_o,
  output logic              dmem_err_o,
  output logic              mem_en_o,
  output logic [ADDR_W-3:0] mem_addr_o,
  output logic [3:0]        mem_we_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  // A zero burst limit still needs a one-bit counter that sits at terminal count.
  localparam int unsigned CW = (MAX_D_BURST == 0) ? 1 : $clog2(MAX_D_BURST + 1);

  logic          igrant_s;
  logic          dgrant_s;
  logic          ierr_s;
  logic          derr_s;
  logic          tc_s;
  logic [CW-1:0] starve_cnt_s;
  resp_owner_t   resp_q;
  resp_owner_t   resp_d;

  assign ierr_s = (imem_addr_i[1:0] != 2'b00);
  assign derr_s = !be_legal(dmem_be_i);

  toast_arb_starve_ctr #(
    .MAX (MAX_D_BURST),
    .CW  (CW)
  ) u_starve (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .clr_i    (!imem_req_i || igrant_s),
    .inc_i    (dgrant_s && imem_req_i),
    .cnt_o    (starve_cnt_s),
    .tc_o     (tc_s)
  );

  // Grant selection; reset masks both grants combinationally.
  always_comb begin
    igrant_s = 1'b0;
    dgrant_s = 1'b0;
    if (!resetn_i) begin
      igrant_s = 1'b0;
      dgrant_s = 1'b0;
    end else if (imem_req_i && dmem_req_i) begin
      igrant_s = tc_s;
      dgrant_s = !tc_s;
    end else if (imem_req_i) begin
      igrant_s = 1'b1;
    end else if (dmem_req_i) begin
      dgrant_s = 1'b1;
    end else begin
      igrant_s = 1'b0;
      dgrant_s = 1'b0;
    end
  end

  assign imem_gnt_o = igrant_s;
  assign dmem_gnt_o = dgrant_s;

  // RAM strobe and write path; erroring requests are granted but never touch RAM.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_addr_o  = '0;
    mem_we_o    = 4'b0000;
    mem_wdata_o = 32'h0000_0000;
    if (igrant_s) begin
      mem_en_o   = !ierr_s;
      mem_addr_o = imem_addr_i[ADDR_W-1:2];
    end else if (dgrant_s) begin
      mem_en_o    = !derr_s;
      mem_addr_o  = dmem_addr_i[ADDR_W-1:2];
      mem_we_o    = derr_s ? 4'b0000 : dmem_be_i;
      mem_wdata_o = dmem_wdata_i;
    end else begin
      mem_en_o = 1'b0;
    end
  end

  // Next response owner follows this cycle's grant.
  always_comb begin
    resp_d = R_NONE;
    if (igrant_s) begin
      resp_d = ierr_s ? R_IERR : R_IMEM;
    end else if (dgrant_s) begin
      resp_d = derr_s ? R_DERR : R_DMEM;
    end else begin
      resp_d = R_NONE;
    end
  end

  // Response owner register; reset drops any response still in flight.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      resp_q <= R_NONE;
    end else begin
      resp_q <= resp_d;
    end
  end

  // Route the RAM read data to the owning port; the other port sees zeros.
  always_comb begin
    imem_rvalid_o = 1'b0;
    imem_err_o    = 1'b0;
    imem_rdata_o  = 32'h0000_0000;
    dmem_rvalid_o = 1'b0;
    dmem_err_o    = 1'b0;
    dmem_rdata_o  = 32'h0000_0000;
    case (resp_q)
      R_IMEM: begin
        imem_rvalid_o = 1'b1;
        imem_rdata_o  = mem_rdata_i;
      end
      R_DMEM: begin
        dmem_rvalid_o = 1'b1;
        dmem_rdata_o  = mem_rdata_i;
      end
      R_IERR: begin
        imem_rvalid_o = 1'b1;
        imem_err_o    = 1'b1;
      end
      R_DERR: begin
        dmem_rvalid_o = 1'b1;
        dmem_err_o    = 1'b1;
      end
      default: begin
        imem_rvalid_o = 1'b0;
        dmem_rvalid_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_toast_mem_arbiter.sv
// Self-checking bench for toast_mem_arbiter: directed test-plan steps followed by
// randomized traffic against a transaction-level reference model.
module tb_toast_mem_arbiter;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        resetn_i;
  logic        imem_req_i;
  logic [31:0] imem_addr_i;
  logic        imem_gnt_o, imem_rvalid_o, imem_err_o;
  logic [31:0] imem_rdata_o;
  logic        dmem_req_i;
  logic [31:0] dmem_addr_i;
  logic [3:0]  dmem_be_i;
  logic [31:0] dmem_wdata_i;
  logic        dmem_gnt_o, dmem_rvalid_o, dmem_err_o;
  logic [31:0] dmem_rdata_o;
  logic        mem_en_o;
  logic [29:0] mem_addr_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  int vectors = 0;
  int miscompares = 0;

  // Environment RAM and the model's own copy of what memory should hold.
  logic [31:0] ram     [0:4095];
  logic [31:0] ref_mem [0:4095];

  // Reference-model state.
  int          cnt_m;
  logic        exp_iv, exp_ie, exp_dv, exp_de;
  logic [31:0] exp_id, exp_dd;
  logic        last_gi, last_gd;

  toast_mem_arbiter #(.ADDR_W(32), .MAX_D_BURST(MAXB)) dut (
    .clk_i(clk), .resetn_i(resetn_i),
    .imem_req_i(imem_req_i), .imem_addr_i(imem_addr_i), .imem_gnt_o(imem_gnt_o),
    .imem_rvalid_o(imem_rvalid_o), .imem_rdata_o(imem_rdata_o), .imem_err_o(imem_err_o),
    .dmem_req_i(dmem_req_i), .dmem_addr_i(dmem_addr_i), .dmem_be_i(dmem_be_i),
    .dmem_wdata_i(dmem_wdata_i), .dmem_gnt_o(dmem_gnt_o), .dmem_rvalid_o(dmem_rvalid_o),
    .dmem_rdata_o(dmem_rdata_o), .dmem_err_o(dmem_err_o),
    .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read-before-write, data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_en_o) begin
      mem_rdata_i <= ram[mem_addr_o[11:0]];
      for (int b = 0; b < 4; b++)
        if (mem_we_o[b]) ram[mem_addr_o[11:0]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    cnt_m   = 0;
    exp_iv  = 1'b0; exp_ie = 1'b0; exp_id = 32'h0;
    exp_dv  = 1'b0; exp_de = 1'b0; exp_dd = 32'h0;
    last_gi = 1'b0; last_gd = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ignt"}, {31'b0, imem_gnt_o}, 32'h0);
    chk({tag, "_dgnt"}, {31'b0, dmem_gnt_o}, 32'h0);
    chk({tag, "_en"}, {31'b0, mem_en_o}, 32'h0);
    chk({tag, "_we"}, {28'b0, mem_we_o}, 32'h0);
    chk({tag, "_ivld"}, {31'b0, imem_rvalid_o}, 32'h0);
    chk({tag, "_dvld"}, {31'b0, dmem_rvalid_o}, 32'h0);
    chk({tag, "_ierr"}, {31'b0, imem_err_o}, 32'h0);
    chk({tag, "_derr"}, {31'b0, dmem_err_o}, 32'h0);
    chk({tag, "_irdata"}, imem_rdata_o, 32'h0);
    chk({tag, "_drdata"}, dmem_rdata_o, 32'h0);
  endtask

  // One clock of traffic: drive, check against the model, advance the model.
  task automatic cycle(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic [31:0] da, input logic [3:0] be, input logic [31:0] wd);
    logic gi, gd, ie, de, en;
    imem_req_i = ir; imem_addr_i = ia;
    dmem_req_i = dr; dmem_addr_i = da; dmem_be_i = be; dmem_wdata_i = wd;
    #2;
    gi = ir && (!dr || cnt_m == MAXB);
    gd = dr && !gi;
    ie = (ia % 4) != 0;
    de = !(be inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111});
    en = (gi && !ie) || (gd && !de);
    chk("imem_gnt", {31'b0, imem_gnt_o}, {31'b0, gi});
    chk("dmem_gnt", {31'b0, dmem_gnt_o}, {31'b0, gd});
    chk("mem_en", {31'b0, mem_en_o}, {31'b0, en});
    if (en) begin
      chk("mem_addr", {2'b0, mem_addr_o}, (gi ? ia : da) / 4);
      chk("mem_we", {28'b0, mem_we_o}, gd ? {28'b0, be} : 32'h0);
      if (gd && be != 4'b0000) chk("mem_wdata", mem_wdata_o, wd);
    end
    chk("imem_rvalid", {31'b0, imem_rvalid_o}, {31'b0, exp_iv});
    chk("imem_err", {31'b0, imem_err_o}, {31'b0, exp_ie});
    chk("imem_rdata", imem_rdata_o, exp_id);
    chk("dmem_rvalid", {31'b0, dmem_rvalid_o}, {31'b0, exp_dv});
    chk("dmem_err", {31'b0, dmem_err_o}, {31'b0, exp_de});
    chk("dmem_rdata", dmem_rdata_o, exp_dd);
    chk("starve_cnt", 32'(dut.starve_cnt_s), 32'(cnt_m));
    exp_iv = gi; exp_ie = gi && ie;
    exp_id = (gi && !ie) ? ref_mem[(ia / 4) % 4096] : 32'h0;
    exp_dv = gd; exp_de = gd && de;
    exp_dd = (gd && !de) ? ref_mem[(da / 4) % 4096] : 32'h0;
    if (gd && !de)
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[(da / 4) % 4096][8*b +: 8] = wd[8*b +: 8];
    if (!ir || gi) cnt_m = 0;
    else if (gd && cnt_m < MAXB) cnt_m = cnt_m + 1;
    last_gi = gi; last_gd = gd;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [9:0]  seq;
  logic        ir_r, dr_r;
  logic [31:0] ia_r, da_r, wd_r;
  logic [3:0]  be_r;
  logic [3:0]  legal_be [8];

  initial begin
    legal_be = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    for (int i = 0; i < 4096; i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end
    ram[0] = 32'h0000_0093;     ref_mem[0] = 32'h0000_0093;
    ram[1] = 32'h0010_0113;     ref_mem[1] = 32'h0010_0113;
    ram[12'h800] = 32'h1122_3344; ref_mem[12'h800] = 32'h1122_3344;

    resetn_i = 1'b0; imem_req_i = 1'b0; imem_addr_i = 32'h0;
    dmem_req_i = 1'b0; dmem_addr_i = 32'h0; dmem_be_i = 4'b0; dmem_wdata_i = 32'h0;
    model_reset();
    @(posedge clk); @(negedge clk);
    chk_all_zero("reset");
    resetn_i = 1'b1;
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 4'b0, 32'h0);

    // Fetch only, back to back.
    cycle(1'b1, 32'h0, 1'b0, 32'h0, 4'b0, 32'h0);
    chk("fetch0_data", imem_rdata_o, 32'h0000_0093);
    cycle(1'b1, 32'h4, 1'b0, 32'h0, 4'b0, 32'h0);
    chk("fetch1_data", imem_rdata_o, 32'h0010_0113);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 4'b0, 32'h0);

    // Continuous tie: four data grants then one fetch, twice.
    seq = 10'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9) chk("starve_at_tc", 32'(dut.starve_cnt_s), 32'd4);
      cycle(1'b1, 32'h8, 1'b1, 32'h100, 4'b0000, 32'h0);
      seq = {seq[8:0], last_gd};
    end
    chk("tie_sequence", {22'b0, seq}, {22'b0, 10'b1111011110});
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 4'b0, 32'h0);

    // Byte store into lane 2, then word load.
    cycle(1'b0, 32'h0, 1'b1, 32'h2002, 4'b0100, 32'h00AB_0000);
    chk("store_ack_old", dmem_rdata_o, 32'h1122_3344);
    cycle(1'b0, 32'h0, 1'b1, 32'h2000, 4'b0000, 32'h0);
    chk("load_merged", dmem_rdata_o, 32'h11AB_3344);

    // Illegal byte enables and misaligned fetch.
    cycle(1'b0, 32'h0, 1'b1, 32'h2000, 4'b0101, 32'hDEAD_BEEF);
    chk("derr_flag", {31'b0, dmem_err_o}, 32'h1);
    cycle(1'b1, 32'h6, 1'b0, 32'h0, 4'b0, 32'h0);
    chk("ierr_flag", {31'b0, imem_err_o}, 32'h1);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 4'b0, 32'h0);

    // Reset asserted in the grant cycle of a data read.
    cycle(1'b1, 32'h8, 1'b1, 32'h2000, 4'b0000, 32'h0);
    imem_req_i = 1'b1; dmem_req_i = 1'b1;
    #2;
    chk("rst_pre_dgnt", {31'b0, dmem_gnt_o}, 32'h1);
    resetn_i = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    @(posedge clk); @(negedge clk);
    imem_req_i = 1'b0; dmem_req_i = 1'b0;
    resetn_i = 1'b1;
    model_reset();
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 4'b0, 32'h0);
    chk("rst_post_dvld", {31'b0, dmem_rvalid_o}, 32'h0);
    chk("rst_post_starve", 32'(dut.starve_cnt_s), 32'h0);

    // Randomized traffic; a request is held until its grant.
    ir_r = 1'b0; dr_r = 1'b0; ia_r = 32'h0; da_r = 32'h0; be_r = 4'b0; wd_r = 32'h0;
    for (int n = 0; n < 400; n++) begin
      if (!ir_r || last_gi) begin
        ir_r = ($urandom_range(0, 3) != 0);
        ia_r = 32'($urandom_range(0, 4095)) * 4;
        if ($urandom_range(0, 7) == 0) ia_r = ia_r + 32'($urandom_range(1, 3));
      end
      if (!dr_r || last_gd) begin
        dr_r = ($urandom_range(0, 3) != 0);
        da_r = 32'($urandom_range(0, 16383));
        be_r = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15))
                                           : legal_be[$urandom_range(0, 7)];
        wd_r = $urandom;
      end
      cycle(ir_r, ia_r, dr_r, da_r, be_r, wd_r);
    end
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 4'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
